// File: rtl/wb_regfile.sv
// wb_regfile: architectural state at the end of the MEM/WB stage.
// Holds 32 GPRs plus HI/LO and serves two combinational GPR read ports and
// a HI/LO read port. Each read port forwards the value being written back
// in the same cycle, so decode sees the result without waiting for the edge.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_hilo_en,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // GPR storage: clear on reset, otherwise commit writes; reg0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // HI/LO storage: the pair is always written together
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_hilo_en) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // Read port 1: reset, enable, reg0, then write-back bypass, then storage
    always_comb begin
        rdata1 = '0;
        if (reset || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (wb_en && (wb_addr == raddr1)) begin
            rdata1 = wb_data;
        end else begin
            rdata1 = gpr[raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        rdata2 = '0;
        if (reset || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (wb_en && (wb_addr == raddr2)) begin
            rdata2 = wb_data;
        end else begin
            rdata2 = gpr[raddr2];
        end
    end

    // HI/LO read with same-cycle bypass of the pending pair
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        if (reset) begin
            hi_out = '0;
            lo_out = '0;
        end else if (wb_hilo_en) begin
            hi_out = wb_hi;
            lo_out = wb_lo;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic against an
// array-based reference model of the register file.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hilo_en;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays
    logic [DATA_W-1:0] m_regs [32];
    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_hilo_en (wb_hilo_en),
        .wb_hi      (wb_hi),
        .wb_lo      (wb_lo),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    function automatic logic [DATA_W-1:0] exp_gpr(input logic re, input logic [ADDR_W-1:0] a);
        if (reset || !re || a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [DATA_W-1:0] exp_hi();
        if (reset) return '0;
        return wb_hilo_en ? wb_hi : m_hi;
    endfunction

    function automatic logic [DATA_W-1:0] exp_lo();
        if (reset) return '0;
        return wb_hilo_en ? wb_lo : m_lo;
    endfunction

    task automatic idle();
        reset = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        wb_hilo_en = 0; wb_hi = 0; wb_lo = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    // Clock edge with model update, returning at the next falling edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (wb_hilo_en) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        reset = 1; re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 9;
        #1;
        checks++;
        if (rdata1 !== 0 || hi_out !== 0 || lo_out !== 0) begin
            errors++;
            $display("FAIL reset_force_initial rdata1=%h hi=%h lo=%h required 0", rdata1, hi_out, lo_out);
        end
        tick();
        idle();
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        wb_hilo_en = 1; wb_hi = 32'h1; wb_lo = 32'h2;
        tick();
        idle();
        re1 = 1; raddr1 = 5; reset = 1;
        #1;
        checks++;
        if (rdata1 !== 0 || hi_out !== 0 || lo_out !== 0) begin
            errors++;
            $display("FAIL reset_force_live rdata1=%h hi=%h lo=%h required 0", rdata1, hi_out, lo_out);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (rdata1 !== 0) begin
            errors++;
            $display("FAIL reset_clears_r5 rdata1=%h required 0", rdata1);
        end
        checks++;
        if (hi_out !== 0 || lo_out !== 0) begin
            errors++;
            $display("FAIL reset_clears_hilo hi=%h lo=%h required 0", hi_out, lo_out);
        end
    endtask

    task automatic test_r0();
        idle();
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; re1 = 1; raddr1 = 0;
        #1;
        checks++;
        if (rdata1 !== 0) begin
            errors++;
            $display("FAIL r0_same_cycle rdata1=%h required 0", rdata1);
        end
        tick();
        wb_en = 0;
        #1;
        checks++;
        if (rdata1 !== 0) begin
            errors++;
            $display("FAIL r0_next_cycle rdata1=%h required 0", rdata1);
        end
    endtask

    task automatic test_bypass();
        idle();
        wb_en = 1; wb_addr = 7; wb_data = 32'h12345678;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        #1;
        checks++;
        if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_same_cycle rdata1=%h rdata2=%h required 12345678", rdata1, rdata2);
        end
        tick();
        wb_en = 0; wb_data = 0;
        #1;
        checks++;
        if (rdata1 !== 32'h12345678 || rdata2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_committed rdata1=%h rdata2=%h required 12345678", rdata1, rdata2);
        end
    endtask

    task automatic test_read_enable();
        idle();
        wb_en = 1; wb_addr = 3; wb_data = 32'hA5A5A5A5;
        tick();
        idle();
        re1 = 0; raddr1 = 3; re2 = 1; raddr2 = 3;
        #1;
        checks++;
        if (rdata1 !== 0) begin
            errors++;
            $display("FAIL re1_gated rdata1=%h required 0", rdata1);
        end
        checks++;
        if (rdata2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL re2_read rdata2=%h required a5a5a5a5", rdata2);
        end
    endtask

    task automatic test_hilo();
        idle();
        wb_hilo_en = 1; wb_hi = 32'hCAFEF00D; wb_lo = 32'h0BADBEEF;
        wb_en = 1; wb_addr = 9; wb_data = 32'h99990009;
        #1;
        checks++;
        if (hi_out !== 32'hCAFEF00D || lo_out !== 32'h0BADBEEF) begin
            errors++;
            $display("FAIL hilo_bypass hi=%h lo=%h required cafef00d/0badbeef", hi_out, lo_out);
        end
        tick();
        idle();
        re1 = 1; raddr1 = 9;
        #1;
        checks++;
        if (hi_out !== 32'hCAFEF00D || lo_out !== 32'h0BADBEEF) begin
            errors++;
            $display("FAIL hilo_commit hi=%h lo=%h required cafef00d/0badbeef", hi_out, lo_out);
        end
        checks++;
        if (rdata1 !== 32'h99990009) begin
            errors++;
            $display("FAIL gpr_with_hilo rdata1=%h required 99990009", rdata1);
        end
    endtask

    task automatic test_reset_drop();
        idle();
        wb_en = 1; wb_addr = 4; wb_data = 32'h55; reset = 1;
        tick();
        idle();
        re2 = 1; raddr2 = 4;
        #1;
        checks++;
        if (rdata2 !== 0) begin
            errors++;
            $display("FAIL reset_drops_write rdata2=%h required 0", rdata2);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2, eh, el;
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            wb_en      = $urandom_range(0, 1);
            wb_addr    = ADDR_W'($urandom_range(0, 7));
            wb_data    = $urandom;
            wb_hilo_en = ($urandom_range(0, 2) == 0);
            wb_hi      = $urandom;
            wb_lo      = $urandom;
            re1        = ($urandom_range(0, 4) != 0);
            raddr1     = ADDR_W'($urandom_range(0, 7));
            re2        = ($urandom_range(0, 4) != 0);
            raddr2     = ($urandom_range(0, 3) == 0) ? raddr1 : ADDR_W'($urandom_range(0, 31));
            #1;
            e1 = exp_gpr(re1, raddr1);
            e2 = exp_gpr(re2, raddr2);
            eh = exp_hi();
            el = exp_lo();
            checks++;
            if (rdata1 !== e1 || rdata2 !== e2) begin
                errors++;
                $display("FAIL rand_gpr n=%0d rdata1=%h rdata2=%h required %h %h", n, rdata1, rdata2, e1, e2);
            end
            checks++;
            if (hi_out !== eh || lo_out !== el) begin
                errors++;
                $display("FAIL rand_hilo n=%0d hi=%h lo=%h required %h %h", n, hi_out, lo_out, eh, el);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_r0();
        test_bypass();
        test_read_enable();
        test_hilo();
        test_reset_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
